instr_fetch: RTL and testbench

Fetch stage of the single-cycle/short-pipeline MIPS CPU: owns the program counter, drives the word address into the read-only instruction memory, and registers the returned 32-bit word together with its PC into the IF/ID register consumed by decode. Supports start-up gating, decode back-pressure (stall), branch/jump redirect with flush, and an optional end-of-program halt.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/if_id_reg.sv | 43 ++++
 rtl/instr_fetch.sv | 124 ++++++++++++
 tb/tb_instr_fetch.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalt
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned CNT_WIDTH = 16;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures instruction and PC when enabled, flush clears only valid.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic [31:0]      instr_i,
    input  logic [WIDTH-1:0] pc_i,
    output logic [31:0]      instr_o,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus1_o,
    output logic             valid_o
);

    logic [31:0]      instr_q;
    logic [WIDTH-1:0] pc_q;
    logic             valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            // Wrong-path or halted: keep the old word visible but mark it as a bubble.
            valid_q <= 1'b0;
        end else if (en_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus1_o = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
    assign valid_o    = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, start/stall/redirect control and IF/ID register.
// Optional end-of-program halt is enabled by defining FETCH_HALT_EN.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LAST_ADDR = 2**WIDTH-1,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [WIDTH-1:0]     redirect_addr_i,
    output logic [WIDTH-1:0]     imem_addr_o,
    input  logic [31:0]          imem_rd_i,
    output logic [31:0]          instr_o,
    output logic [WIDTH-1:0]     pc_o,
    output logic [WIDTH-1:0]     pc_plus1_o,
    output logic                 valid_o,
    output logic                 halted_o,
    output logic [CNT_WIDTH-1:0] fetch_count_o
);

    fetch_state_e         state_q;
    logic [WIDTH-1:0]     pc_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 capture;
    logic                 flush;

    assign capture = (state_q == StRun) && !redirect_i && !stall_i;
    // Redirect flushes in RUN/HALT; HALT also retires the last word on any unstalled edge.
    assign flush   = ((state_q != StIdle) && redirect_i) || ((state_q == StHalt) && !stall_i);

`ifdef FETCH_HALT_EN
    logic halted_q;
    logic at_last;

    assign at_last = (pc_q == LAST_ADDR[WIDTH-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC[WIDTH-1:0];
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: if (start_i) state_q <= StRun;
                StRun: begin
                    if (redirect_i) begin
                        pc_q <= redirect_addr_i;
                    end else if (!stall_i) begin
                        if (count_q != '1) count_q <= count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        if (at_last) begin
                            state_q  <= StHalt;
                            halted_q <= 1'b1;
                        end else begin
                            pc_q <= pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
                StHalt: begin
                    if (redirect_i) begin
                        state_q  <= StRun;
                        pc_q     <= redirect_addr_i;
                        halted_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign halted_o = halted_q;
`else
    logic unused_last_addr;

    assign unused_last_addr = ^LAST_ADDR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC[WIDTH-1:0];
            count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: if (start_i) state_q <= StRun;
                StRun: begin
                    if (redirect_i) begin
                        pc_q <= redirect_addr_i;
                    end else if (!stall_i) begin
                        if (count_q != '1) count_q <= count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        pc_q <= pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign halted_o = 1'b0;
`endif

    assign imem_addr_o   = pc_q;
    assign fetch_count_o = count_q;

    if_id_reg #(
        .WIDTH(WIDTH)
    ) u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (capture),
        .flush_i   (flush),
        .instr_i   (imem_rd_i),
        .pc_i      (pc_q),
        .instr_o   (instr_o),
        .pc_o      (pc_o),
        .pc_plus1_o(pc_plus1_o),
        .valid_o   (valid_o)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; halt checks are built when FETCH_HALT_EN is defined.
module tb_instr_fetch;

    localparam int unsigned W = 8;
`ifdef FETCH_HALT_EN
    localparam int unsigned TB_LAST = 4;
`else
    localparam int unsigned TB_LAST = 255;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic          stall_i;
    logic          redirect_i;
    logic [W-1:0]  redirect_addr_i;
    logic [W-1:0]  imem_addr_o;
    logic [31:0]   imem_rd_i;
    logic [31:0]   instr_o;
    logic [W-1:0]  pc_o;
    logic [W-1:0]  pc_plus1_o;
    logic          valid_o;
    logic          halted_o;
    logic [15:0]   fetch_count_o;

    logic [31:0] mem [256];
    int n_total = 0;
    int n_bad   = 0;

    instr_fetch #(
        .WIDTH    (W),
        .LAST_ADDR(TB_LAST),
        .RESET_PC (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .stall_i        (stall_i),
        .redirect_i     (redirect_i),
        .redirect_addr_i(redirect_addr_i),
        .imem_addr_o    (imem_addr_o),
        .imem_rd_i      (imem_rd_i),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .pc_plus1_o     (pc_plus1_o),
        .valid_o        (valid_o),
        .halted_o       (halted_o),
        .fetch_count_o  (fetch_count_o)
    );

    always #5 clk = ~clk;
    assign imem_rd_i = mem[imem_addr_o];

    function automatic logic [31:0] word(input int unsigned a);
        if (a == 0) return 32'h2001_00CA;
        if (a == 1) return 32'h0021_0820;
        return {16'hA5A5, 8'h00, a[7:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic exp_valid, input int unsigned exp_pc,
                                input logic [31:0] exp_instr, input int unsigned exp_cnt,
                                input int unsigned exp_addr);
        check({tag, ".valid"}, 32'(valid_o), 32'(exp_valid));
        check({tag, ".pc"}, 32'(pc_o), exp_pc);
        check({tag, ".instr"}, instr_o, exp_instr);
        check({tag, ".count"}, 32'(fetch_count_o), exp_cnt);
        check({tag, ".addr"}, 32'(imem_addr_o), exp_addr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        expect_state(tag, 1'b0, 0, 32'h0, 0, 0);
        check({tag, ".pc1"}, 32'(pc_plus1_o), 32'd1);
        check({tag, ".halted"}, 32'(halted_o), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = word(i);
        rst_n = 1'b0;
        start_i = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_addr_i = '0;
        #1;
        check_reset_vals("reset");
        step();
        step();
        rst_n = 1'b1;

        step();
        step();
        expect_state("idle", 1'b0, 0, 32'h0, 0, 0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        expect_state("start_edge", 1'b0, 0, 32'h0, 0, 0);
        step();
        expect_state("fetch0", 1'b1, 0, 32'h2001_00CA, 1, 1);
        step();
        expect_state("fetch1", 1'b1, 1, 32'h0021_0820, 2, 2);
        check("fetch1.pc1", 32'(pc_plus1_o), 32'd2);

        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_state($sformatf("stall%0d", i), 1'b1, 1, 32'h0021_0820, 2, 2);
        end
        stall_i = 1'b0;
        step();
        expect_state("resume", 1'b1, 2, word(2), 3, 3);

        redirect_i = 1'b1;
        redirect_addr_i = 8'h10;
        stall_i = 1'b1;
        step();
        redirect_i = 1'b0;
        stall_i = 1'b0;
        expect_state("redir_bubble", 1'b0, 2, word(2), 3, 16);
        step();
        expect_state("redir_target", 1'b1, 16, word(16), 4, 17);

`ifdef FETCH_HALT_EN
        redirect_i = 1'b1;
        redirect_addr_i = 8'd3;
        step();
        redirect_i = 1'b0;
        expect_state("h_bubble", 1'b0, 16, word(16), 4, 3);
        step();
        expect_state("h_pc3", 1'b1, 3, word(3), 5, 4);
        check("h_pc3.halted", 32'(halted_o), 32'd0);
        step();
        expect_state("h_pc4", 1'b1, 4, word(4), 6, 4);
        check("h_pc4.halted", 32'(halted_o), 32'd1);
        step();
        expect_state("h_hold0", 1'b0, 4, word(4), 6, 4);
        step();
        expect_state("h_hold1", 1'b0, 4, word(4), 6, 4);
        check("h_hold1.halted", 32'(halted_o), 32'd1);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        expect_state("h_start_ign", 1'b0, 4, word(4), 6, 4);
        redirect_i = 1'b1;
        redirect_addr_i = 8'd0;
        step();
        redirect_i = 1'b0;
        expect_state("h_restart", 1'b0, 4, word(4), 6, 0);
        check("h_restart.halted", 32'(halted_o), 32'd0);
        step();
        expect_state("h_pc0", 1'b1, 0, 32'h2001_00CA, 7, 1);
`else
        redirect_i = 1'b1;
        redirect_addr_i = 8'd254;
        step();
        redirect_i = 1'b0;
        expect_state("w_bubble", 1'b0, 16, word(16), 4, 254);
        step();
        expect_state("w_pc254", 1'b1, 254, word(254), 5, 255);
        step();
        expect_state("w_pc255", 1'b1, 255, word(255), 6, 0);
        check("w_pc255.pc1", 32'(pc_plus1_o), 32'd0);
        check("w_pc255.halted", 32'(halted_o), 32'd0);
        step();
        expect_state("w_pc0", 1'b1, 0, 32'h2001_00CA, 7, 1);
        check("w_pc0.pc1", 32'(pc_plus1_o), 32'd1);
`endif

        redirect_i = 1'b1;
        redirect_addr_i = 8'd5;
        step();
        redirect_i = 1'b0;
        check("pre_rst.addr", 32'(imem_addr_o), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        #2;
        rst_n = 1'b1;
        step();
        step();
        expect_state("post_rst_idle", 1'b0, 0, 32'h0, 0, 0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        expect_state("post_rst_fetch", 1'b1, 0, 32'h2001_00CA, 1, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
